// File: rtl/id_ex_stage_buf.sv
// ID->EX pipeline register with valid/ready handshake, capture-time operand forwarding,
// late operand patching while stalled, flush-to-bubble and saturating performance counters.
module id_ex_stage_buf #(
    parameter int unsigned     PAYLOAD_W = 192,
    parameter int unsigned     OPND_W    = 64,
    parameter int unsigned     NUM_OPND  = 2,
    parameter int unsigned     PC_W      = 64,
    parameter logic [PC_W-1:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [NUM_OPND*OPND_W-1:0] in_opnd,
    input  logic [NUM_OPND-1:0]        fwd_en,
    input  logic [NUM_OPND-1:0]        fwd_block,
    input  logic [NUM_OPND*OPND_W-1:0] fwd_data,
    input  logic [NUM_OPND-1:0]        upd_en,
    input  logic [NUM_OPND*OPND_W-1:0] upd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [PC_W-1:0]            out_pc,
    output logic [NUM_OPND*OPND_W-1:0] out_opnd,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                       state_q, state_d;
    logic                         accept;
    logic                         hold;
    logic [NUM_OPND*OPND_W-1:0]   opnd_d;

    assign out_valid = (state_q == FULL);
    assign in_ready  = flush | ~out_valid | out_ready;
    assign accept    = in_valid & in_ready & ~flush;
    assign hold      = out_valid & ~out_ready & ~flush;

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (out_ready)
            state_d = EMPTY;
    end

    // Capture selects forwarded data unless blocked; a held entry takes late patches instead.
    always_comb begin
        opnd_d = out_opnd;
        for (int unsigned i = 0; i < NUM_OPND; i++) begin
            if (accept)
                opnd_d[i*OPND_W +: OPND_W] = (fwd_en[i] && !fwd_block[i]) ?
                                             fwd_data[i*OPND_W +: OPND_W] :
                                             in_opnd[i*OPND_W +: OPND_W];
            else if (hold && upd_en[i])
                opnd_d[i*OPND_W +: OPND_W] = upd_data[i*OPND_W +: OPND_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_payload <= '0;
            out_pc      <= RESET_PC;
            out_opnd    <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                out_payload <= '0;
                out_pc      <= RESET_PC;
                out_opnd    <= '0;
            end else begin
                if (accept) begin
                    out_payload <= in_payload;
                    out_pc      <= in_pc;
                end
                out_opnd <= opnd_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (!out_valid && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_ONE;
            if (flush && out_valid && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule
